// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types for the stall/flush controller
package rv32i_types;

    typedef enum logic {
        INIT,
        RUN
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic load;
        logic flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_HOLD   = '{load: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t STAGE_LOAD   = '{load: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t STAGE_BUBBLE = '{load: 1'b0, flush: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at its all-ones value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for the 5-stage RV32I pipeline
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             imem_busy_i,
    input  logic             dmem_busy_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    output logic             pc_load_o,
    output logic             if_id_load_o,
    output logic             if_id_flush_o,
    output logic             id_ex_load_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_load_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_load_o,
    output logic             mem_wb_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    pipe_ctrl_state_t state;
    logic [3:0]       init_cnt;
    logic             kill_q;
    logic             kill_d;
    logic             load_use;
    logic             pc_load;
    logic             flush_inc;
    logic             stall_inc;
    stage_ctrl_t      if_id, id_ex, ex_mem, mem_wb;

    assign load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                      ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        pc_load   = 1'b0;
        if_id     = STAGE_BUBBLE;
        id_ex     = STAGE_BUBBLE;
        ex_mem    = STAGE_BUBBLE;
        mem_wb    = STAGE_BUBBLE;
        kill_d    = kill_q;
        flush_inc = 1'b0;
        if (state == RUN) begin
            if (dmem_busy_i) begin
                // Freeze everything up to MEM; the redirect waits in the held EX stage
                if_id  = STAGE_HOLD;
                id_ex  = STAGE_HOLD;
                ex_mem = STAGE_HOLD;
            end else if (ex_redirect_i) begin
                pc_load   = 1'b1;
                ex_mem    = STAGE_LOAD;
                mem_wb    = STAGE_LOAD;
                flush_inc = 1'b1;
                if (imem_busy_i) begin
                    kill_d = 1'b1;
                end
            end else if (kill_q && !imem_busy_i) begin
                id_ex  = STAGE_LOAD;
                ex_mem = STAGE_LOAD;
                mem_wb = STAGE_LOAD;
                kill_d = 1'b0;
            end else if (load_use) begin
                if_id  = STAGE_HOLD;
                ex_mem = STAGE_LOAD;
                mem_wb = STAGE_LOAD;
            end else if (imem_busy_i) begin
                id_ex  = STAGE_LOAD;
                ex_mem = STAGE_LOAD;
                mem_wb = STAGE_LOAD;
            end else begin
                pc_load = 1'b1;
                if_id   = STAGE_LOAD;
                id_ex   = STAGE_LOAD;
                ex_mem  = STAGE_LOAD;
                mem_wb  = STAGE_LOAD;
            end
        end
    end

    assign stall_inc = (state == RUN) && !pc_load;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= INIT;
            init_cnt <= 4'd0;
            kill_q   <= 1'b0;
        end else begin
            kill_q <= kill_d;
            if (state == INIT) begin
                init_cnt <= init_cnt + 4'd1;
                if (init_cnt == 4'(INIT_CYCLES - 1)) begin
                    state <= RUN;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (stall_inc),
        .cnt    (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (flush_inc),
        .cnt    (flush_cnt_o)
    );

    assign pc_load_o      = pc_load;
    assign if_id_load_o   = if_id.load;
    assign if_id_flush_o  = if_id.flush;
    assign id_ex_load_o   = id_ex.load;
    assign id_ex_flush_o  = id_ex.flush;
    assign ex_mem_load_o  = ex_mem.load;
    assign ex_mem_flush_o = ex_mem.flush;
    assign mem_wb_load_o  = mem_wb.load;
    assign mem_wb_flush_o = mem_wb.flush;

endmodule
